// File: rtl/ibex_cheri_ex_ctrl.sv
// Execute-stage sequencer: valid/ready input, registered result stage, mult/div start/kill,
// CHERI exception priority encoding and a saturating stall counter.
module ibex_cheri_ex_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CAP_W = 93,
  parameter int unsigned EXC_W = 22,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               in_sel_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic [CAP_W-1:0]         cheri_result_i,
  input  logic                     cheri_wrote_cap_i,
  input  logic [EXC_W-1:0]         cheri_exc_a_i,
  input  logic [EXC_W-1:0]         cheri_exc_b_i,
  output logic                     md_start_o,
  output logic                     md_kill_o,
  input  logic                     md_valid_i,
  input  logic [XLEN-1:0]          md_result_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CAP_W-1:0]         out_wdata_o,
  output logic                     out_is_cap_o,
  output logic                     out_exc_o,
  output logic                     out_exc_src_o,
  output logic [$clog2(EXC_W)-1:0] out_exc_cause_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);
  localparam int unsigned CAUSE_W = $clog2(EXC_W);

  typedef enum logic {IDLE, MD_WAIT} state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [CAP_W-1:0]   wdata_q, wdata_d;
  logic               is_cap_q, is_cap_d;
  logic               exc_q, exc_d;
  logic               exc_src_q, exc_src_d;
  logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   md_tag_q, md_tag_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               accept;
  logic               exc_any;
  logic               exc_src;
  logic [EXC_W-1:0]   exc_vec;
  logic [CAUSE_W-1:0] exc_cause;

  assign in_ready_o = (state_q == IDLE) && !flush_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Operand A wins; the lowest set bit of the winning vector is the cause.
  always_comb begin
    exc_any   = (|cheri_exc_a_i) || (|cheri_exc_b_i);
    exc_src   = !(|cheri_exc_a_i) && (|cheri_exc_b_i);
    exc_vec   = (|cheri_exc_a_i) ? cheri_exc_a_i : cheri_exc_b_i;
    exc_cause = '0;
    for (int i = int'(EXC_W) - 1; i >= 0; i--) begin
      if (exc_vec[i]) exc_cause = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    is_cap_d    = is_cap_q;
    exc_d       = exc_q;
    exc_src_d   = exc_src_q;
    exc_cause_d = exc_cause_q;
    tag_d       = tag_q;
    md_tag_d    = md_tag_q;
    stall_d     = stall_q;
    md_start_o  = 1'b0;
    md_kill_o   = 1'b0;

    if (((out_valid_q && !out_ready_i) || (state_q == MD_WAIT)) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      md_kill_o   = (state_q == MD_WAIT);
    end else begin
      if (out_ready_i) out_valid_d = 1'b0;
      if (state_q == MD_WAIT) begin
        if (md_valid_i) begin
          out_valid_d = 1'b1;
          wdata_d     = CAP_W'(md_result_i);
          is_cap_d    = 1'b0;
          exc_d       = 1'b0;
          exc_src_d   = 1'b0;
          exc_cause_d = '0;
          tag_d       = md_tag_q;
          state_d     = IDLE;
        end
      end else if (accept) begin
        tag_d       = in_tag_i;
        is_cap_d    = 1'b0;
        exc_d       = 1'b0;
        exc_src_d   = 1'b0;
        exc_cause_d = '0;
        unique case (in_sel_i)
          2'd0: begin
            out_valid_d = 1'b1;
            wdata_d     = CAP_W'(alu_result_i);
          end
          2'd1: begin
            out_valid_d = 1'b1;
            wdata_d     = cheri_result_i;
            is_cap_d    = cheri_wrote_cap_i;
            exc_d       = exc_any;
            exc_src_d   = exc_src;
            exc_cause_d = exc_cause;
          end
          2'd2: begin
            md_start_o = 1'b1;
            md_tag_d   = in_tag_i;
            state_d    = MD_WAIT;
          end
          default: begin
            out_valid_d = 1'b1;
            wdata_d     = '0;
          end
        endcase
      end
    end

    // The mult/div unit shares rst_i, so no pulses go out while resetting.
    if (rst_i) begin
      md_start_o = 1'b0;
      md_kill_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      is_cap_q    <= 1'b0;
      exc_q       <= 1'b0;
      exc_src_q   <= 1'b0;
      exc_cause_q <= '0;
      tag_q       <= '0;
      md_tag_q    <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      is_cap_q    <= is_cap_d;
      exc_q       <= exc_d;
      exc_src_q   <= exc_src_d;
      exc_cause_q <= exc_cause_d;
      tag_q       <= tag_d;
      md_tag_q    <= md_tag_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_wdata_o     = wdata_q;
  assign out_is_cap_o    = is_cap_q;
  assign out_exc_o       = exc_q;
  assign out_exc_src_o   = exc_src_q;
  assign out_exc_cause_o = exc_cause_q;
  assign out_tag_o       = tag_q;
  assign busy_o          = (state_q != IDLE) || out_valid_q;
  assign stall_cnt_o     = stall_q;

endmodule

// File: tb/tb_ibex_cheri_ex_ctrl.sv
// Bench for ibex_cheri_ex_ctrl: vector table plus hand sequences, results checked via a scoreboard queue.
module tb_ibex_cheri_ex_ctrl;
  localparam int CAP_W = 93;
  localparam int EXC_W = 22;
  localparam int TAG_W = 5;
  localparam int CW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid, in_ready_o, wrote, md_start_o, md_kill_o, md_valid, flush;
  logic [1:0]       sel;
  logic [TAG_W-1:0] tag;
  logic [31:0]      alu_res, md_res;
  logic [CAP_W-1:0] cheri_res;
  logic [EXC_W-1:0] exc_a, exc_b;
  logic             out_valid_o, out_ready, out_is_cap_o, out_exc_o, out_exc_src_o, busy_o;
  logic [CAP_W-1:0] out_wdata_o;
  logic [CW-1:0]    out_exc_cause_o;
  logic [TAG_W-1:0] out_tag_o;
  logic [15:0]      stall_cnt_o;

  logic             s_in_ready, s_md_start, s_md_kill, s_out_valid, s_is_cap, s_exc, s_src, s_busy;
  logic [CAP_W-1:0] s_wdata;
  logic [CW-1:0]    s_cause;
  logic [TAG_W-1:0] s_tag;
  logic [2:0]       s_stall;

  ibex_cheri_ex_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_sel_i(sel),
    .in_tag_i(tag), .alu_result_i(alu_res), .cheri_result_i(cheri_res), .cheri_wrote_cap_i(wrote),
    .cheri_exc_a_i(exc_a), .cheri_exc_b_i(exc_b), .md_start_o(md_start_o), .md_kill_o(md_kill_o),
    .md_valid_i(md_valid), .md_result_i(md_res), .flush_i(flush), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready), .out_wdata_o(out_wdata_o), .out_is_cap_o(out_is_cap_o),
    .out_exc_o(out_exc_o), .out_exc_src_o(out_exc_src_o), .out_exc_cause_o(out_exc_cause_o),
    .out_tag_o(out_tag_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  ibex_cheri_ex_ctrl #(.CNT_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_sel_i(sel),
    .in_tag_i(tag), .alu_result_i(alu_res), .cheri_result_i(cheri_res), .cheri_wrote_cap_i(wrote),
    .cheri_exc_a_i(exc_a), .cheri_exc_b_i(exc_b), .md_start_o(s_md_start), .md_kill_o(s_md_kill),
    .md_valid_i(md_valid), .md_result_i(md_res), .flush_i(flush), .out_valid_o(s_out_valid),
    .out_ready_i(out_ready), .out_wdata_o(s_wdata), .out_is_cap_o(s_is_cap),
    .out_exc_o(s_exc), .out_exc_src_o(s_src), .out_exc_cause_o(s_cause),
    .out_tag_o(s_tag), .busy_o(s_busy), .stall_cnt_o(s_stall)
  );

  typedef struct {
    logic [CAP_W-1:0] wdata;
    logic             cap, exc, src;
    logic [CW-1:0]    cause;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct {
    logic [1:0]       sel;
    logic [TAG_W-1:0] tag;
    logic [31:0]      alu;
    logic [CAP_W-1:0] cheri;
    logic             wrote;
    logic [EXC_W-1:0] ea, eb;
    res_t             exp;
  } vec_t;

  res_t sbq[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [CAP_W-1:0] C1 = 93'h1_2345_6789_ABCD_EF01_2345;
  localparam logic [CAP_W-1:0] C2 = 93'h0_F00D_0000_0000_1111_2222;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got tag %0d wdata %0h expected none", out_tag_o, out_wdata_o);
      end else begin
        res_t e;
        e = sbq.pop_front();
        chk("sb_wdata", out_wdata_o, e.wdata);
        chk("sb_is_cap", out_is_cap_o, e.cap);
        chk("sb_exc", out_exc_o, e.exc);
        chk("sb_exc_src", out_exc_src_o, e.src);
        chk("sb_exc_cause", out_exc_cause_o, e.cause);
        chk("sb_tag", out_tag_o, e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [TAG_W-1:0] t, input logic [31:0] a,
                       input logic [CAP_W-1:0] c, input logic w, input logic [EXC_W-1:0] ea,
                       input logic [EXC_W-1:0] eb);
    in_valid = 1'b1; sel = s; tag = t; alu_res = a; cheri_res = c; wrote = w; exc_a = ea; exc_b = eb;
  endtask

  function automatic res_t mk(input logic [CAP_W-1:0] w, input logic cap, input logic exc,
                              input logic src, input logic [CW-1:0] cause, input logic [TAG_W-1:0] t);
    res_t r;
    r.wdata = w; r.cap = cap; r.exc = exc; r.src = src; r.cause = cause; r.tag = t;
    return r;
  endfunction

  task automatic setv(input int i, input logic [1:0] s, input logic [TAG_W-1:0] t, input logic [31:0] a,
                      input logic [CAP_W-1:0] c, input logic w, input logic [EXC_W-1:0] ea,
                      input logic [EXC_W-1:0] eb, input res_t e);
    vecs[i].sel = s; vecs[i].tag = t; vecs[i].alu = a; vecs[i].cheri = c; vecs[i].wrote = w;
    vecs[i].ea = ea; vecs[i].eb = eb; vecs[i].exp = e;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; md_valid = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (sbq.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk(nm, sbq.size(), 0);
  endtask

  initial begin
    setv(0, 2'd0, 5'd3,  32'hDEADBEEF, C1, 1'b0, 22'h0, 22'h0,
         mk(93'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3));
    setv(1, 2'd1, 5'd1,  32'h0, C1, 1'b1, 22'h0, 22'h000300, mk(C1, 1'b1, 1'b1, 1'b1, 5'd8, 5'd1));
    setv(2, 2'd1, 5'd2,  32'h0, C2, 1'b0, 22'h200000, 22'h000300, mk(C2, 1'b0, 1'b1, 1'b0, 5'd21, 5'd2));
    setv(3, 2'd1, 5'd4,  32'h0, C1, 1'b1, 22'h0, 22'h0, mk(C1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4));
    setv(4, 2'd3, 5'd5,  32'h1234, C1, 1'b1, 22'h1, 22'h1, mk(93'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5));
    setv(5, 2'd0, 5'd6,  32'hFFFFFFFF, C2, 1'b1, 22'h3FFFFF, 22'h3FFFFF,
         mk(93'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6));
    setv(6, 2'd1, 5'd7,  32'h0, C2, 1'b1, 22'h0000A1, 22'h000002, mk(C2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd7));
    setv(7, 2'd1, 5'd31, 32'h0, C1, 1'b0, 22'h0, 22'h200000, mk(C1, 1'b0, 1'b1, 1'b1, 5'd21, 5'd31));
    setv(8, 2'd1, 5'd0,  32'h0, C2, 1'b0, 22'h0F0000, 22'h0, mk(C2, 1'b0, 1'b1, 1'b0, 5'd16, 5'd0));

    in_valid = 0; sel = 0; tag = 0; alu_res = 0; cheri_res = 0; wrote = 0; exc_a = 0; exc_b = 0;
    md_valid = 0; md_res = 0; flush = 0; out_ready = 1'b1; rst = 1'b1;

    tick();
    tick();
    settle();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_wdata", out_wdata_o, 0);
    chk("rst_tag", out_tag_o, 0);
    chk("rst_exc", out_exc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_md_start", md_start_o, 0);
    chk("rst_md_kill", md_kill_o, 0);
    rst = 1'b0;

    // Table: back-to-back accepts with writeback always ready.
    for (int i = 0; i < 9; i++) begin
      tick();
      drive(vecs[i].sel, vecs[i].tag, vecs[i].alu, vecs[i].cheri, vecs[i].wrote, vecs[i].ea, vecs[i].eb);
      settle();
      chk("tbl_in_ready", in_ready_o, 1);
      chk("tbl_md_start", md_start_o, 0);
      if (i > 0) chk("tbl_out_valid", out_valid_o, 1);
      sbq.push_back(vecs[i].exp);
    end
    tick();
    in_valid = 1'b0;
    wait_drain("tbl_drain");

    // Held result with writeback stalled, then three back-to-back ops.
    do_reset();
    out_ready = 1'b0;
    drive(2'd0, 5'd5, 32'h55, C1, 1'b0, 22'h0, 22'h0);
    settle();
    chk("hold_accept_ready", in_ready_o, 1);
    sbq.push_back(mk(93'h55, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5));
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("hold_in_ready", in_ready_o, 0);
      chk("hold_valid", out_valid_o, 1);
      chk("hold_wdata", out_wdata_o, 93'h55);
      chk("hold_tag", out_tag_o, 5);
      tick();
    end
    out_ready = 1'b1;
    settle();
    chk("hold_stall", stall_cnt_o, 4);
    chk("hold_in_ready_drain", in_ready_o, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 5'(10 + i), 32'h100 + 32'(i), C1, 1'b0, 22'h0, 22'h0);
      settle();
      chk("b2b_in_ready", in_ready_o, 1);
      if (i > 0) chk("b2b_valid", out_valid_o, 1);
      sbq.push_back(mk(93'h100 + 93'(i), 1'b0, 1'b0, 1'b0, 5'd0, 5'(10 + i)));
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("b2b_valid_last", out_valid_o, 1);
    wait_drain("b2b_drain");

    // Mult/div: start pulse, blocked input during MD_WAIT, result after md_valid.
    do_reset();
    drive(2'd2, 5'd9, 32'h0, C1, 1'b0, 22'h0, 22'h0);
    settle();
    chk("md_accept_ready", in_ready_o, 1);
    chk("md_start_pulse", md_start_o, 1);
    tick();
    tag = 5'd7;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        in_valid = 1'b0;
        md_valid = 1'b1;
        md_res = 32'h12345678;
        sbq.push_back(mk(93'h12345678, 1'b0, 1'b0, 1'b0, 5'd0, 5'd9));
      end
      settle();
      chk("md_wait_start", md_start_o, 0);
      chk("md_wait_ready", in_ready_o, 0);
      chk("md_wait_busy", busy_o, 1);
      chk("md_wait_valid", out_valid_o, 0);
      tick();
    end
    md_valid = 1'b0;
    settle();
    chk("md_result_valid", out_valid_o, 1);
    chk("md_stall", stall_cnt_o, 5);
    tick();
    md_valid = 1'b1;
    md_res = 32'hBADBAD;
    tick();
    md_valid = 1'b0;
    settle();
    chk("md_valid_idle_ignored", out_valid_o, 0);
    wait_drain("md_drain");

    // Flush in MD_WAIT with a coincident mult/div result.
    do_reset();
    drive(2'd2, 5'd4, 32'h0, C1, 1'b0, 22'h0, 22'h0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    md_valid = 1'b1;
    md_res = 32'hBAD;
    drive(2'd0, 5'd1, 32'hAAAA, C1, 1'b0, 22'h0, 22'h0);
    settle();
    chk("flush_kill", md_kill_o, 1);
    chk("flush_in_ready", in_ready_o, 0);
    tick();
    flush = 1'b0;
    md_valid = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("flush_kill_done", md_kill_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_in_ready_after", in_ready_o, 1);
    chk("flush_busy", busy_o, 0);
    chk("flush_stall_kept", stall_cnt_o, 3);
    out_ready = 1'b0;
    drive(2'd0, 5'd6, 32'h66, C1, 1'b0, 22'h0, 22'h0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    settle();
    chk("flush_idle_no_kill", md_kill_o, 0);
    chk("flush_held_valid", out_valid_o, 1);
    tick();
    flush = 1'b0;
    settle();
    chk("flush_held_cleared", out_valid_o, 0);
    chk("flush_held_stall", stall_cnt_o, 4);
    out_ready = 1'b1;
    tick();

    // Stall counter saturation in the 3-bit instance.
    do_reset();
    out_ready = 1'b0;
    drive(2'd0, 5'd2, 32'h77, C1, 1'b0, 22'h0, 22'h0);
    sbq.push_back(mk(93'h77, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2));
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    settle();
    chk("sat_small", s_stall, 7);
    chk("sat_big", stall_cnt_o, 10);
    chk("sat_wdata_held", out_wdata_o, 93'h77);
    out_ready = 1'b1;
    tick();
    wait_drain("sat_drain");

    // Reset while the mult/div is running clears everything without a kill.
    drive(2'd2, 5'd8, 32'h0, C1, 1'b0, 22'h0, 22'h0);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    flush = 1'b1;
    settle();
    chk("rst_md_no_kill", md_kill_o, 0);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    settle();
    chk("rst_md_out_valid", out_valid_o, 0);
    chk("rst_md_wdata", out_wdata_o, 0);
    chk("rst_md_tag", out_tag_o, 0);
    chk("rst_md_busy", busy_o, 0);
    chk("rst_md_stall", stall_cnt_o, 0);
    chk("rst_md_stall_small", s_stall, 0);
    chk("rst_md_kill_after", md_kill_o, 0);
    chk("rst_md_in_ready", in_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
